// File: rtl/ras_ctrl.sv
// ras_ctrl: decode-stage call/return classifier driving return-stack push/pop strobes, a mirrored depth and a valid/ack fetch redirect
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
module ras_ctrl #(
  parameter int entry_num  = 32,
  parameter int addr_width = $clog2(entry_num)
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic                   dec_valid,
  input  logic [31:0]            instr_dec,
  input  logic [`ADDR_WIDTH-1:0] pc_dec,
  input  logic                   flush,
  input  logic [`ADDR_WIDTH-1:0] ret_addr,
  input  logic                   fetch_ack,
  output logic                   dec_stall,
  output logic                   ret_stack_wen,
  output logic                   ret_stack_ren,
  output logic [`ADDR_WIDTH-1:0] ras_pc,
  output logic                   ras_redirect,
  output logic [`ADDR_WIDTH-1:0] ras_target,
  output logic [addr_width-1:0]  ras_depth,
  output logic [15:0]            drop_cnt
);
  localparam logic [1:0] IDLE = 2'd0, CORO = 2'd1, REDIR = 2'd2;
  logic [1:0] state, state_nxt;
  logic [`ADDR_WIDTH-1:0] coro_pc;
  logic coro_pop;
  logic [4:0] rd, rs1;
  logic rd_link, rs1_link, is_jal, is_jalr, is_push, is_pop, is_swap;
  logic fire, full, empty, push_req, pop_req, drop_inc;
  logic unused_bits;
  assign unused_bits = ^instr_dec[31:20];
  assign rd       = instr_dec[11:7];
  assign rs1      = instr_dec[19:15];
  assign rd_link  = rd == 5'd1 || rd == 5'd5;
  assign rs1_link = rs1 == 5'd1 || rs1 == 5'd5;
  assign is_jal   = instr_dec[6:0] == 7'b1101111;
  assign is_jalr  = instr_dec[6:0] == 7'b1100111 && instr_dec[14:12] == 3'b000;
  assign is_push  = (is_jal && rd_link) || (is_jalr && rd_link && (!rs1_link || rs1 == rd));
  assign is_pop   = is_jalr && !rd_link && rs1_link;
  assign is_swap  = is_jalr && rd_link && rs1_link && rs1 != rd;
  assign full     = ras_depth == addr_width'(entry_num - 1);
  assign empty    = ras_depth == '0;
  always_comb begin
    dec_stall     = state != IDLE;
    ras_redirect  = state == REDIR;
    fire          = dec_valid && !dec_stall && !flush && state == IDLE;
    pop_req       = fire && (is_pop || is_swap);
    push_req      = (fire && is_push) || (state == CORO && !flush);
    ret_stack_ren = pop_req && !empty;
    ret_stack_wen = push_req && !full;
    drop_inc      = (push_req && full) || (pop_req && empty);
    ras_pc        = ret_stack_wen ? (state == CORO ? coro_pc : pc_dec) : '0;
    state_nxt     = flush ? IDLE :
                    state == IDLE  ? (fire && is_swap ? CORO : ret_stack_ren ? REDIR : IDLE) :
                    state == CORO  ? (coro_pop ? REDIR : IDLE) :
                    state == REDIR ? (fetch_ack ? IDLE : REDIR) : IDLE;
  end
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= IDLE;
      ras_depth  <= '0;
      drop_cnt   <= '0;
      ras_target <= '0;
      coro_pc    <= '0;
      coro_pop   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ret_stack_wen) ras_depth <= ras_depth + 1'b1;
      else if (ret_stack_ren) ras_depth <= ras_depth - 1'b1;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (ret_stack_ren) ras_target <= ret_addr;
      if (fire && is_swap) begin
        coro_pc  <= pc_dec;
        coro_pop <= !empty;
      end
    end
  end
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: scoreboard bench for ras_ctrl call/return/swap/flush/reset behaviour
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
module tb_ras_ctrl;
  localparam int AW = `ADDR_WIDTH;
  logic cpu_clk = 0, cpu_rst = 1, dec_valid = 0, flush = 0, fetch_ack = 0;
  logic [31:0] instr_dec = 0;
  logic [AW-1:0] pc_dec = 0, ret_addr = 0;
  logic dec_stall, ret_stack_wen, ret_stack_ren, ras_redirect;
  logic [AW-1:0] ras_pc, ras_target;
  logic [4:0] ras_depth;
  logic [15:0] drop_cnt;
  int checks = 0, errors = 0;
  logic [AW-1:0] exp_q[$];
  ras_ctrl dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .dec_valid(dec_valid), .instr_dec(instr_dec),
    .pc_dec(pc_dec), .flush(flush), .ret_addr(ret_addr), .fetch_ack(fetch_ack),
    .dec_stall(dec_stall), .ret_stack_wen(ret_stack_wen), .ret_stack_ren(ret_stack_ren),
    .ras_pc(ras_pc), .ras_redirect(ras_redirect), .ras_target(ras_target),
    .ras_depth(ras_depth), .drop_cnt(drop_cnt)
  );
  always #5 cpu_clk = ~cpu_clk;
  function automatic logic [31:0] jal(input logic [4:0] rd);
    return {20'b0, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'b0, rs1, 3'b000, rd, 7'b1100111};
  endfunction
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [AW-1:0] pc, input logic [AW-1:0] ra);
    dec_valid = v; instr_dec = ins; pc_dec = pc; ret_addr = ra;
    #1;
  endtask
  task automatic do_reset();
    dec_valid = 0; flush = 0; fetch_ack = 0;
    cpu_rst = 1;
    tick();
    cpu_rst = 0;
    tick();
  endtask
  task automatic wait_redirect(input string name);
    logic [AW-1:0] e;
    int n = 0;
    while (!ras_redirect && n < 10) begin tick(); n++; end
    checks++;
    if (!ras_redirect || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: redirect=%0b queued=%0d, required redirect=1 with queued target", name, ras_redirect, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({ras_target, dec_stall} !== {e, 1'b1}) begin
        errors++;
        $display("FAIL %s: target=%h stall=%0b, required target=%h stall=1", name, ras_target, dec_stall, e);
      end
    end
  endtask
  task automatic test_reset();
    cpu_rst = 1;
    #1;
    checks++;
    if ({dec_stall, ret_stack_wen, ret_stack_ren, ras_redirect, ras_target, ras_depth, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: stall=%0b wen=%0b ren=%0b redir=%0b tgt=%h depth=%0d drop=%0d, required all 0",
               dec_stall, ret_stack_wen, ret_stack_ren, ras_redirect, ras_target, ras_depth, drop_cnt);
    end
    do_reset();
  endtask
  task automatic test_call_return();
    drive(1, jal(1), 'h100, 0);
    checks++;
    if ({ret_stack_wen, ret_stack_ren, ras_pc} !== {2'b10, AW'('h100)}) begin
      errors++; $display("FAIL call_strobe: wen=%0b ren=%0b pc=%h, required 1 0 100", ret_stack_wen, ret_stack_ren, ras_pc);
    end
    tick();
    checks++;
    if (ras_depth !== 5'd1) begin errors++; $display("FAIL call_depth: got %0d required 1", ras_depth); end
    drive(1, jalr(0, 1), 'h180, 'h104);
    exp_q.push_back('h104);
    checks++;
    if ({ret_stack_wen, ret_stack_ren, ras_redirect} !== 3'b010) begin
      errors++; $display("FAIL ret_strobe: wen=%0b ren=%0b redir=%0b, required 0 1 0", ret_stack_wen, ret_stack_ren, ras_redirect);
    end
    tick();
    dec_valid = 0; ret_addr = 'hdead;
    checks++;
    if (ras_redirect !== 1'b1) begin errors++; $display("FAIL ret_latency: redirect=%0b required 1", ras_redirect); end
    wait_redirect("ret_target");
    tick();
    checks++;
    if ({ras_redirect, ras_target} !== {1'b1, AW'('h104)}) begin
      errors++; $display("FAIL ret_hold: redir=%0b tgt=%h, required 1 104", ras_redirect, ras_target);
    end
    fetch_ack = 1;
    tick();
    fetch_ack = 0;
    checks++;
    if ({ras_redirect, dec_stall, ras_depth, ras_target} !== {2'b00, 5'd0, AW'('h104)}) begin
      errors++; $display("FAIL ret_ack: redir=%0b stall=%0b depth=%0d tgt=%h, required 0 0 0 104", ras_redirect, dec_stall, ras_depth, ras_target);
    end
  endtask
  task automatic test_underflow();
    drive(1, jalr(0, 1), 'h300, 'h444);
    checks++;
    if (ret_stack_ren !== 1'b0) begin errors++; $display("FAIL underflow_ren: got %0b required 0", ret_stack_ren); end
    tick();
    dec_valid = 0;
    checks++;
    if ({ras_redirect, ras_depth, drop_cnt} !== {1'b0, 5'd0, 16'd1}) begin
      errors++; $display("FAIL underflow_state: redir=%0b depth=%0d drop=%0d, required 0 0 1", ras_redirect, ras_depth, drop_cnt);
    end
  endtask
  task automatic test_back_to_back();
    int bad = 0;
    for (int i = 0; i < 31; i++) begin
      drive(1, jal(5), AW'(32'h1000 + 4 * i), 0);
      if ({ret_stack_wen, ras_pc} !== {1'b1, AW'(32'h1000 + 4 * i)}) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || ras_depth !== 5'd31) begin
      errors++; $display("FAIL b2b_calls: bad_strobes=%0d depth=%0d, required 0 31", bad, ras_depth);
    end
    drive(1, jal(1), 'h2000, 0);
    checks++;
    if (ret_stack_wen !== 1'b0) begin errors++; $display("FAIL overflow_wen: got %0b required 0", ret_stack_wen); end
    tick();
    dec_valid = 0;
    checks++;
    if ({ras_depth, drop_cnt} !== {5'd31, 16'd2}) begin
      errors++; $display("FAIL overflow_state: depth=%0d drop=%0d, required 31 2", ras_depth, drop_cnt);
    end
  endtask
  task automatic test_swap();
    do_reset();
    drive(1, jal(1), 'h10, 0); tick();
    drive(1, jal(1), 'h20, 0); tick();
    drive(1, jalr(5, 1), 'h200, 'h300);
    exp_q.push_back('h300);
    checks++;
    if ({ret_stack_wen, ret_stack_ren, ras_depth} !== {2'b01, 5'd2}) begin
      errors++; $display("FAIL swap_c0: wen=%0b ren=%0b depth=%0d, required 0 1 2", ret_stack_wen, ret_stack_ren, ras_depth);
    end
    tick();
    ret_addr = 'hbad;
    checks++;
    if ({ret_stack_wen, ret_stack_ren, ras_pc, dec_stall, ras_redirect} !== {2'b10, AW'('h200), 2'b10}) begin
      errors++; $display("FAIL swap_c1: wen=%0b ren=%0b pc=%h stall=%0b redir=%0b, required 1 0 200 1 0",
                         ret_stack_wen, ret_stack_ren, ras_pc, dec_stall, ras_redirect);
    end
    tick();
    dec_valid = 0;
    checks++;
    if (ras_redirect !== 1'b1) begin errors++; $display("FAIL swap_latency: redirect=%0b required 1", ras_redirect); end
    wait_redirect("swap_target");
    fetch_ack = 1; tick(); fetch_ack = 0;
    checks++;
    if ({dec_stall, ras_depth} !== {1'b0, 5'd2}) begin
      errors++; $display("FAIL swap_depth: stall=%0b depth=%0d, required 0 2", dec_stall, ras_depth);
    end
  endtask
  task automatic test_flush();
    drive(1, jalr(0, 5), 'h400, 'h500);
    exp_q.push_back('h500);
    tick();
    wait_redirect("flush_redir_target");
    drive(1, jalr(0, 1), 'h404, 'h600);
    flush = 1; fetch_ack = 0;
    #1;
    checks++;
    if ({ret_stack_ren, ret_stack_wen} !== 2'b00) begin
      errors++; $display("FAIL flush_redir_strobes: ren=%0b wen=%0b, required 0 0", ret_stack_ren, ret_stack_wen);
    end
    tick();
    checks++;
    if ({ras_redirect, dec_stall, ret_stack_ren, ras_depth} !== {3'b000, 5'd1}) begin
      errors++; $display("FAIL flush_redir: redir=%0b stall=%0b ren=%0b depth=%0d, required 0 0 0 1", ras_redirect, dec_stall, ret_stack_ren, ras_depth);
    end
    tick();
    flush = 0; dec_valid = 0;
    checks++;
    if ({ras_redirect, ras_depth, ras_target} !== {1'b0, 5'd1, AW'('h500)}) begin
      errors++; $display("FAIL flush_idle_pop: redir=%0b depth=%0d tgt=%h, required 0 1 500", ras_redirect, ras_depth, ras_target);
    end
  endtask
  task automatic test_coro_reset();
    drive(1, jalr(1, 5), 'h700, 'h800);
    tick();
    dec_valid = 0;
    checks++;
    if ({ret_stack_wen, ras_pc} !== {1'b1, AW'('h700)}) begin
      errors++; $display("FAIL coro_enter: wen=%0b pc=%h, required 1 700", ret_stack_wen, ras_pc);
    end
    cpu_rst = 1;
    #1;
    checks++;
    if ({ret_stack_wen, ret_stack_ren, dec_stall, ras_redirect, ras_pc, ras_target, ras_depth, drop_cnt} !== '0) begin
      errors++; $display("FAIL coro_reset: wen=%0b ren=%0b stall=%0b redir=%0b pc=%h tgt=%h depth=%0d drop=%0d, required all 0",
                         ret_stack_wen, ret_stack_ren, dec_stall, ras_redirect, ras_pc, ras_target, ras_depth, drop_cnt);
    end
    tick();
    cpu_rst = 0;
    tick(); tick();
    checks++;
    if ({ras_depth, ret_stack_wen, ras_redirect} !== {5'd0, 2'b00}) begin
      errors++; $display("FAIL coro_no_push: depth=%0d wen=%0b redir=%0b, required 0 0 0", ras_depth, ret_stack_wen, ras_redirect);
    end
  endtask
  initial begin
    test_reset();
    test_call_return();
    test_underflow();
    test_back_to_back();
    test_swap();
    test_flush();
    test_coro_reset();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d targets left, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
